wb_burst_ram: RTL and testbench

Wishbone B4 slave (responder) backing the instruction-cache refill path. It answers the cache's master cycles, both classic single transfers and incrementing bursts selected by CTI, from an on-chip synchronous word RAM. Registered-feedback design: the first ACK comes one cycle after the request, then one ACK per cycle for the rest of a burst. It sits on the memory side of the cache's Wishbone port and is also the reference target for cache-level benches.

---
 rtl/wb_pkg.sv | 24 ++
 rtl/wb_ram_array.sv | 36 +++
 rtl/wb_burst_ram.sv | 128 ++++++++++++
 tb/tb_wb_burst_ram.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared Wishbone B4 definitions for the instruction-cache refill path:
//   cti_t       - cycle type identifier encodings carried on CTI_I
//   slv_state_t - state encoding of the burst RAM slave FSM
//   WB_DATA_W   - Wishbone data width
// ---------------------------------------------------------------------------
package wb_pkg;

    localparam int WB_DATA_W = 32;

    typedef enum logic [2:0] {
        CTI_CLASSIC = 3'b000,
        CTI_CONST   = 3'b001,
        CTI_INC     = 3'b010,
        CTI_EOB     = 3'b111
    } cti_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BEAT = 1'b1
    } slv_state_t;

endpackage

// File: rtl/wb_ram_array.sv
// ---------------------------------------------------------------------------
// wb_ram_array
// Single-port synchronous word RAM with one-cycle read latency.
// A write and a read share the one address; the read returns the old word
// when both target the same location in the same cycle.
// Parameters:
//   DEPTH_LOG2 - log2 of the depth in words
//   INIT_FILE  - hex image loaded at elaboration ("" = no preload)
// Ports:
//   clk   in   clock
//   addr  in   word index
//   we    in   write enable
//   wdata in   write word
//   rdata out  read word, valid the cycle after addr is presented
// ---------------------------------------------------------------------------
module wb_ram_array
    import wb_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter     INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic                  we,
    input  logic [WB_DATA_W-1:0]  wdata,
    output logic [WB_DATA_W-1:0]  rdata
);

    logic [WB_DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/wb_burst_ram.sv
// ---------------------------------------------------------------------------
// wb_burst_ram
// Wishbone B4 slave answering classic and incrementing-burst cycles from an
// on-chip word RAM. First ACK one cycle after the request, then one ACK per
// cycle for the remainder of a burst. The read for the next beat is issued
// speculatively during the current ACK cycle.
// Optional feature macro: WB_BURST_RAM_ERR_EN
//   defined   - requests with ADR[31:DEPTH_LOG2+2] != 0 are answered with ERR
//               (no write, DAT_O = 0) and the burst ends
//   undefined - upper address bits ignored (aliasing), ERR tied to 0
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   CYC, STB, WE  bus cycle, strobe, write enable
//   ADR           byte address (word index ADR[DEPTH_LOG2+1:2])
//   DAT_I         write data
//   CTI_I         cycle type identifier
//   DAT_O         read data (0 on write and error beats)
//   ACK, ERR, RTY acknowledge, error, retry (RTY always 0)
// ---------------------------------------------------------------------------
module wb_burst_ram
    import wb_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter     INIT_FILE  = ""
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 CYC,
    input  logic                 STB,
    input  logic                 WE,
    input  logic [31:0]          ADR,
    input  logic [WB_DATA_W-1:0] DAT_I,
    input  logic [2:0]           CTI_I,
    output logic [WB_DATA_W-1:0] DAT_O,
    output logic                 ACK,
    output logic                 ERR,
    output logic                 RTY
);

    slv_state_t            state, state_nxt;
    logic [DEPTH_LOG2-1:0] cnt, cnt_nxt;
    logic [DEPTH_LOG2-1:0] req_idx;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [WB_DATA_W-1:0]  ram_rdata;
    logic                  ram_we;
    logic                  we_q;
    logic                  err_q;
    logic                  beat_ok;
    logic                  unused_adr;

    assign req_idx    = ADR[DEPTH_LOG2+1:2];
    assign unused_adr = ^{ADR[1:0], ADR[31:DEPTH_LOG2+2]};

    assign beat_ok = (state == ST_BEAT) && !err_q;
    // rst blocks the commit so a write beat caught by reset leaves no trace.
    assign ram_we  = beat_ok && CYC && STB && WE && !rst;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ram_addr  = cnt;
        case (state)
            ST_IDLE: begin
                ram_addr = req_idx;
                if (CYC && STB) begin
                    state_nxt = ST_BEAT;
                    cnt_nxt   = req_idx;
                end
            end
            ST_BEAT: begin
                // The single port serves the write when committing; otherwise
                // it prefetches the next beat. A write burst never needs the
                // prefetched word because write beats return 0.
                ram_addr  = ram_we ? cnt : cnt + 1'b1;
                state_nxt = ST_IDLE;
                if (!err_q && CYC && STB && (CTI_I == CTI_INC)) begin
                    state_nxt = ST_BEAT;
                    cnt_nxt   = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            we_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == ST_IDLE && CYC && STB) we_q <= WE;
        end
    end

`ifdef WB_BURST_RAM_ERR_EN
    // Range check uses only the first beat's address; later ADR is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state == ST_IDLE && CYC && STB) begin
            err_q <= |ADR[31:DEPTH_LOG2+2];
        end
    end
`else
    assign err_q = 1'b0;
`endif

    wb_ram_array #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .INIT_FILE  (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (DAT_I),
        .rdata (ram_rdata)
    );

    assign ACK   = beat_ok;
    assign ERR   = (state == ST_BEAT) && err_q;
    assign RTY   = 1'b0;
    assign DAT_O = (beat_ok && !we_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_wb_burst_ram.sv
module tb_wb_burst_ram;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst, cyc, stb, we;
    logic [31:0] adr, dat_i, dat_o;
    logic [2:0]  cti;
    logic        ack, err, rty;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] ref_mem [DEPTH];

    always #5 clk = ~clk;

    wb_burst_ram #(
        .DEPTH_LOG2 (10),
        .INIT_FILE  ("")
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .CYC   (cyc),
        .STB   (stb),
        .WE    (we),
        .ADR   (adr),
        .DAT_I (dat_i),
        .CTI_I (cti),
        .DAT_O (dat_o),
        .ACK   (ack),
        .ERR   (err),
        .RTY   (rty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
            $error("check %s", tag);
        end
    endtask

    // One bus transaction. cut >= 0 interrupts it during that beat's ACK
    // cycle: mode 0 drops CYC+STB, mode 1 asserts rst, mode 2 drops STB.
    task automatic xfer(input int start, input int len, input bit wr, input bit classic,
                        input logic [31:0] upper, input int cut, input int cut_mode,
                        input bit fixed, input logic [31:0] base);
        bit          exp_err;
        int          idx;
        logic [31:0] wd;
        exp_err = 1'b0;
`ifdef WB_BURST_RAM_ERR_EN
        exp_err = (upper != 32'd0);
`endif
        @(negedge clk);
        cyc   = 1'b1;
        stb   = 1'b1;
        we    = wr;
        adr   = upper | (32'(start % DEPTH) << 2) | 32'($urandom_range(0, 3));
        cti   = classic ? 3'b000 : 3'b010;
        dat_i = $urandom;
        if (exp_err) begin
            @(negedge clk);
            chk("err_err", err, 1);
            chk("err_ack", ack, 0);
            chk("err_dat", dat_o, 0);
            cti   = 3'b010;
            dat_i = $urandom;
            @(negedge clk);
            chk("err_end_ack", ack, 0);
            chk("err_end_err", err, 0);
            cyc = 1'b0;
            stb = 1'b0;
            we  = 1'b0;
            return;
        end
        for (int k = 0; k < len; k++) begin
            idx = (start + k) % DEPTH;
            @(negedge clk);
            chk("ack", ack, 1);
            chk("err", err, 0);
            chk("rty", rty, 0);
            chk(wr ? "dat_o_wr" : "dat_o_rd", dat_o, wr ? 32'd0 : ref_mem[idx]);
            if (k == cut) begin
                if (cut_mode == 0) begin
                    cyc = 1'b0;
                    stb = 1'b0;
                end else if (cut_mode == 1) begin
                    rst = 1'b1;
                end else begin
                    stb = 1'b0;
                end
                dat_i = $urandom;
                @(negedge clk);
                chk("cut_ack", ack, 0);
                chk("cut_err", err, 0);
                chk("cut_dat", dat_o, 0);
                rst = 1'b0;
                cyc = 1'b0;
                stb = 1'b0;
                we  = 1'b0;
                return;
            end
            wd    = fixed ? base + 32'(k) : $urandom;
            dat_i = wd;
            if (wr) ref_mem[idx] = wd;
            cti   = (k == len - 1) ? (classic ? 3'b000 : 3'b111) : 3'b010;
            adr   = $urandom;
        end
        @(negedge clk);
        chk("end_ack", ack, 0);
        chk("end_err", err, 0);
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, l;
        bit w, c;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = '0; dat_i = '0; cti = 3'b000;
        repeat (3) @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_rty", rty, 0);
        chk("rst_dat", dat_o, 0);
        rst = 1'b0;

        // Fill the whole RAM with known random words.
        xfer(0, DEPTH, 1, 0, 32'd0, -1, 0, 0, 32'd0);

        // Classic write then read of mem[5] (ADR 0x14).
        xfer(5, 1, 1, 1, 32'd0, -1, 0, 1, 32'hDEAD_BEEF);
        xfer(5, 1, 0, 1, 32'd0, -1, 0, 0, 32'd0);

        // 8-beat incrementing read at ADR 0x20.
        xfer(8, 8, 0, 0, 32'd0, -1, 0, 0, 32'd0);

        // 4-beat write at ADR 0x40 with 1..4, then classic readback.
        xfer(16, 4, 1, 0, 32'd0, -1, 0, 1, 32'd1);
        for (int i = 16; i < 20; i++) xfer(i, 1, 0, 1, 32'd0, -1, 0, 0, 32'd0);

        // Wrap from the last word to word 0.
        xfer(1023, 3, 0, 0, 32'd0, -1, 0, 0, 32'd0);
        xfer(1022, 4, 1, 0, 32'd0, -1, 0, 0, 32'd0);
        xfer(1022, 4, 0, 0, 32'd0, -1, 0, 0, 32'd0);

        // CYC dropped during beat 2 of a write burst; mem[2] keeps old value.
        xfer(0, 6, 1, 0, 32'd0, 2, 0, 0, 32'd0);
        xfer(0, 4, 0, 0, 32'd0, -1, 0, 0, 32'd0);

        // Reset during beat 3 of a write burst; beat 3 not written.
        xfer(32, 6, 1, 0, 32'd0, 3, 1, 0, 32'd0);
        xfer(32, 6, 0, 0, 32'd0, -1, 0, 0, 32'd0);
        xfer(35, 1, 0, 1, 32'd0, -1, 0, 0, 32'd0);

        // STB dropped mid read burst.
        xfer(100, 5, 0, 0, 32'd0, 1, 2, 0, 32'd0);

        // Out-of-range address 0x0001_0000 (ERR, or alias of word 0).
        xfer(0, 1, 1, 1, 32'h0001_0000, -1, 0, 1, 32'hA5A5_0000);
        xfer(0, 1, 0, 1, 32'h0001_0000, -1, 0, 0, 32'd0);
        xfer(0, 1, 0, 1, 32'd0, -1, 0, 0, 32'd0);
        xfer(7, 4, 0, 0, 32'h8000_0000, -1, 0, 0, 32'd0);
        xfer(7, 4, 0, 0, 32'd0, -1, 0, 0, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 30; i++) begin
            s = int'($urandom_range(0, DEPTH - 1));
            l = int'($urandom_range(1, 16));
            w = 1'($urandom_range(0, 1));
            c = (l == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            xfer(s, l, w, c, 32'd0, -1, 0, 0, 32'd0);
            if (w) xfer(s, l, 0, 0, 32'd0, -1, 0, 0, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
